screen_line_drawer: RTL

- Bresenham line rasteriser sitting directly downstream of the screen-wipe datapath.
- Accepts an endpoint pair (x0,y0)-(x1,y1) on a start pulse and emits one pixel coordinate per clock to the frame-buffer writer.
- Covers all octants on the 640x480 display; reports busy/done so the wipe controller can sequence the next line.

---
 rtl/screen_line_drawer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/screen_line_drawer.sv
// -----------------------------------------------------------------------------
// screen_line_drawer
//   Bresenham line rasteriser covering all octants. A start pulse latches an
//   endpoint pair; after one setup cycle the block emits one pixel coordinate
//   per clock, ending on (x1,y1), then pulses done for one cycle.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        one-cycle request, endpoints sampled in the same cycle
//   x0,y0,x1,y1  line endpoints
//   x,y          current pixel coordinate
//   pixel_valid  x/y carry a pixel to plot this cycle
//   busy         line in progress (setup + draw)
//   done         one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module screen_line_drawer #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int ERR_W = 12
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           pixel_valid,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

  state_t                  state_q;
  logic [X_W-1:0]          x0_q, x1_q, x_q;
  logic [Y_W-1:0]          y0_q, y1_q, y_q;
  logic signed [ERR_W-1:0] dx_q, dy_q, err_q;
  logic                    sx_q, sy_q;   // 1 = step +1, 0 = step -1
  logic                    pixel_valid_q, busy_q, done_q;

  // Setup-cycle values derived from the latched endpoints.
  logic [X_W-1:0]          dx_abs;
  logic [Y_W-1:0]          dy_abs;
  logic signed [ERR_W-1:0] dx_init, dy_init;

  // Per-pixel step decision.
  logic signed [ERR_W:0]   e2, dx_ext, dy_ext;
  logic                    step_x, step_y, at_end;
  logic signed [ERR_W-1:0] err_d;

  always_comb begin
    dx_abs  = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    dy_abs  = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    dx_init = $signed({{(ERR_W-X_W){1'b0}}, dx_abs});
    // dy is kept negative so both error updates are plain additions.
    dy_init = -$signed({{(ERR_W-Y_W){1'b0}}, dy_abs});

    // e2 carries one extra bit so doubling the accumulator cannot overflow.
    e2      = $signed({err_q, 1'b0});
    dx_ext  = $signed({dx_q[ERR_W-1], dx_q});
    dy_ext  = $signed({dy_q[ERR_W-1], dy_q});
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    err_d   = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);

    at_end  = (x_q == x1_q) && (y_q == y1_q);
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others; blocking here would chain updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      err_q         <= '0;
      sx_q          <= 1'b0;
      sy_q          <= 1'b0;
      pixel_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            busy_q  <= 1'b1;
            state_q <= INIT;
          end
        end

        INIT: begin
          dx_q          <= dx_init;
          dy_q          <= dy_init;
          err_q         <= dx_init + dy_init;
          sx_q          <= (x0_q < x1_q);
          sy_q          <= (y0_q < y1_q);
          x_q           <= x0_q;
          y_q           <= y0_q;
          pixel_valid_q <= 1'b1;
          state_q       <= DRAW;
        end

        DRAW: begin
          if (at_end) begin
            // Endpoint is on the outputs this cycle; x/y hold it through DONE.
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= DONE;
          end else begin
            err_q <= err_d;
            if (step_x) x_q <= sx_q ? x_q + X_W'(1) : x_q - X_W'(1);
            if (step_y) y_q <= sy_q ? y_q + Y_W'(1) : y_q - Y_W'(1);
          end
        end

        DONE: begin
          // A start seen here is deliberately dropped.
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign pixel_valid = pixel_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
